// File: rtl/bank_arb_pkg.sv
// Shared types and default constants for the bank-group round-robin arbiter.
// Grant state, end-of-grant event encoding and the parameter defaults used by the sub-modules.
package bank_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Why the previous grant ended; held for exactly one cycle after the exit edge.
    typedef enum logic [1:0] {
        EVT_NONE    = 2'b00,
        EVT_BUDGET  = 2'b01,
        EVT_TIMEOUT = 2'b10
    } arb_evt_t;

    localparam int DEF_NUM_GROUPS = 4;
    localparam int DEF_MAX_BURSTS = 8;
    localparam int DEF_TIMEOUT    = 64;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority finder: returns the first requesting index after i_base, wrapping modulo
// NUM_GROUPS, with i_base itself considered last.
module rr_pick
    import bank_arb_pkg::*;
#(
    parameter  int NUM_GROUPS = DEF_NUM_GROUPS,
    localparam int SEL_W      = $clog2(NUM_GROUPS)
) (
    input  logic [NUM_GROUPS-1:0] i_req,
    input  logic [SEL_W-1:0]      i_base,
    output logic [SEL_W-1:0]      o_idx,
    output logic                  o_valid
);

    logic [SEL_W-1:0] w_cand;

    // Scan from the farthest offset down so the nearest requester after i_base is written last.
    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        w_cand  = '0;
        for (int k = NUM_GROUPS; k >= 1; k--) begin
            w_cand = SEL_W'((int'(i_base) + k) % NUM_GROUPS);
            if (i_req[w_cand]) begin
                o_idx   = w_cand;
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bank_group_rr_arbiter.sv
// Grants one bank-group scheduler at a time to the burst handler with round-robin rotation,
// a per-grant burst budget and an idle timeout.
module bank_group_rr_arbiter
    import bank_arb_pkg::*;
#(
    parameter  int NUM_GROUPS = DEF_NUM_GROUPS,
    parameter  int MAX_BURSTS = DEF_MAX_BURSTS,
    parameter  int TIMEOUT    = DEF_TIMEOUT,
    localparam int SEL_W      = $clog2(NUM_GROUPS)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_flag,
    input  logic [NUM_GROUPS-1:0] i_req,
    input  logic [NUM_GROUPS-1:0] i_done,
    output logic [NUM_GROUPS-1:0] o_start,
    output logic [SEL_W-1:0]      o_sel,
    output logic                  o_busy,
    output logic                  o_evt_budget,
    output logic                  o_evt_timeout
);

    localparam int CNT_W = $clog2(MAX_BURSTS + 1);
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    arb_state_t       r_state;
    logic [SEL_W-1:0] r_owner;
    logic [CNT_W-1:0] r_burstCnt;
    logic [TMR_W-1:0] r_timer;
    arb_evt_t         r_evt;

    arb_state_t       w_stateNext;
    logic [SEL_W-1:0] w_ownerNext;
    logic [CNT_W-1:0] w_burstCntNext;
    logic [TMR_W-1:0] w_timerNext;
    arb_evt_t         w_evtNext;
    logic             w_enter;

    logic [SEL_W-1:0] w_pickIdx;
    logic             w_pickValid;
    logic             w_ownerReq;
    logic             w_ownerDone;
    logic             w_budgetHit;
    logic             w_timeoutHit;
    logic             w_exit;

    // The same finder serves both the idle wake-up and the back-to-back handover on exit.
    rr_pick #(
        .NUM_GROUPS (NUM_GROUPS)
    ) u_pick (
        .i_req   (i_req),
        .i_base  (r_owner),
        .o_idx   (w_pickIdx),
        .o_valid (w_pickValid)
    );

    assign w_ownerReq   = i_req[r_owner];
    assign w_ownerDone  = i_done[r_owner];
    assign w_budgetHit  = w_ownerDone && (r_burstCnt == CNT_W'(MAX_BURSTS - 1));
    assign w_timeoutHit = !w_ownerDone && (r_timer == TMR_W'(TIMEOUT - 1));
    assign w_exit       = !w_ownerReq || w_budgetHit || w_timeoutHit;

    always_comb begin
        w_stateNext    = r_state;
        w_ownerNext    = r_owner;
        w_burstCntNext = r_burstCnt;
        w_timerNext    = r_timer;
        w_evtNext      = EVT_NONE;
        w_enter        = 1'b0;

        case (r_state)
            IDLE: begin
                if (i_flag && w_pickValid) begin
                    w_enter = 1'b1;
                end
            end
            GRANT: begin
                if (w_exit) begin
                    // A final done on a dropped request still reports as budget; a timeout
                    // only reports when the owner is still asking.
                    if (w_budgetHit) begin
                        w_evtNext = EVT_BUDGET;
                    end else if (w_timeoutHit && w_ownerReq) begin
                        w_evtNext = EVT_TIMEOUT;
                    end
                    if (i_flag && w_pickValid) begin
                        w_enter = 1'b1;
                    end else begin
                        w_stateNext    = IDLE;
                        w_burstCntNext = '0;
                        w_timerNext    = '0;
                    end
                end else if (w_ownerDone) begin
                    w_burstCntNext = r_burstCnt + CNT_W'(1);
                    w_timerNext    = '0;
                end else begin
                    w_timerNext = r_timer + TMR_W'(1);
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase

        if (w_enter) begin
            w_stateNext    = GRANT;
            w_ownerNext    = w_pickIdx;
            w_burstCntNext = '0;
            w_timerNext    = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_owner    <= '0;
            r_burstCnt <= '0;
            r_timer    <= '0;
            r_evt      <= EVT_NONE;
        end else begin
            r_state    <= w_stateNext;
            r_owner    <= w_ownerNext;
            r_burstCnt <= w_burstCntNext;
            r_timer    <= w_timerNext;
            r_evt      <= w_evtNext;
        end
    end

    // Outputs come only from registers so the burst handler never sees a path from req.
    always_comb begin
        o_start = '0;
        if (r_state == GRANT) begin
            o_start[r_owner] = 1'b1;
        end
    end

    assign o_sel         = (r_state == GRANT) ? r_owner : '0;
    assign o_busy        = (r_state == GRANT);
    assign o_evt_budget  = (r_evt == EVT_BUDGET);
    assign o_evt_timeout = (r_evt == EVT_TIMEOUT);

endmodule

// File: tb/tb_bank_group_rr_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic on a 4-group and an 8-group arbiter,
// compared every cycle against a behavioural model of the grant rules.
module tb_bank_group_rr_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst4, flag4;
    logic [3:0] req4, done4, start4;
    logic [1:0] sel4;
    logic       busy4, evtB4, evtT4;

    logic       rst8, flag8;
    logic [7:0] req8, done8, start8;
    logic [2:0] sel8;
    logic       busy8, evtB8, evtT8;

    int compared   = 0;
    int mismatched = 0;

    // Model state per instance: index 0 is the 4-group DUT, index 1 the 8-group DUT.
    int mBusy[2]  = '{0, 0};
    int mOwner[2] = '{0, 0};
    int mCnt[2]   = '{0, 0};
    int mTmr[2]   = '{0, 0};
    int mEvtB[2]  = '{0, 0};
    int mEvtT[2]  = '{0, 0};

    bank_group_rr_arbiter #(.NUM_GROUPS(4), .MAX_BURSTS(2), .TIMEOUT(8)) dut4 (
        .i_clk(clk), .i_rst(rst4), .i_flag(flag4), .i_req(req4), .i_done(done4),
        .o_start(start4), .o_sel(sel4), .o_busy(busy4),
        .o_evt_budget(evtB4), .o_evt_timeout(evtT4)
    );

    bank_group_rr_arbiter #(.NUM_GROUPS(8), .MAX_BURSTS(2), .TIMEOUT(8)) dut8 (
        .i_clk(clk), .i_rst(rst8), .i_flag(flag8), .i_req(req8), .i_done(done8),
        .o_start(start8), .o_sel(sel8), .o_busy(busy8),
        .o_evt_budget(evtB8), .o_evt_timeout(evtT8)
    );

    function automatic int pickGroup(input int n, input logic [7:0] req, input int base);
        for (int k = 1; k <= n; k++) begin
            if (req[(base + k) % n]) return (base + k) % n;
        end
        return -1;
    endfunction

    task automatic modelStep(input int w, input int n, input int maxB, input int tmo,
                             input logic rst, input logic flag,
                             input logic [7:0] req, input logic [7:0] done);
        int   p;
        logic ownerReq, ownerDone;
        bit   budget, tmoHit;
        p = pickGroup(n, req, mOwner[w]);
        mEvtB[w] = 0;
        mEvtT[w] = 0;
        if (rst) begin
            mBusy[w] = 0; mOwner[w] = 0; mCnt[w] = 0; mTmr[w] = 0;
        end else if (mBusy[w] == 0) begin
            if (flag && p >= 0) begin
                mBusy[w] = 1; mOwner[w] = p; mCnt[w] = 0; mTmr[w] = 0;
            end
        end else begin
            ownerReq  = req[mOwner[w]];
            ownerDone = done[mOwner[w]];
            budget    = ownerDone && (mCnt[w] + 1 == maxB);
            tmoHit    = !ownerDone && (mTmr[w] + 1 == tmo);
            if (!ownerReq || budget || tmoHit) begin
                mEvtB[w] = budget;
                mEvtT[w] = tmoHit && ownerReq;
                mCnt[w]  = 0;
                mTmr[w]  = 0;
                if (flag && p >= 0) mOwner[w] = p;
                else                mBusy[w]  = 0;
            end else if (ownerDone) begin
                mCnt[w] = mCnt[w] + 1;
                mTmr[w] = 0;
            end else begin
                mTmr[w] = mTmr[w] + 1;
            end
        end
    endtask

    task automatic cmpVal(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input int w);
        logic [7:0] expStart;
        logic [7:0] expSel;
        expStart = (mBusy[w] != 0) ? (8'b1 << mOwner[w]) : 8'b0;
        expSel   = (mBusy[w] != 0) ? 8'(mOwner[w]) : 8'b0;
        if (w == 0) begin
            cmpVal("start4", {4'b0, start4}, expStart);
            cmpVal("sel4", {6'b0, sel4}, expSel);
            cmpVal("busy4", {7'b0, busy4}, 8'(mBusy[w]));
            cmpVal("evtBudget4", {7'b0, evtB4}, 8'(mEvtB[w]));
            cmpVal("evtTimeout4", {7'b0, evtT4}, 8'(mEvtT[w]));
        end else begin
            cmpVal("start8", start8, expStart);
            cmpVal("sel8", {5'b0, sel8}, expSel);
            cmpVal("busy8", {7'b0, busy8}, 8'(mBusy[w]));
            cmpVal("evtBudget8", {7'b0, evtB8}, 8'(mEvtB[w]));
            cmpVal("evtTimeout8", {7'b0, evtT8}, 8'(mEvtT[w]));
        end
    endtask

    // Drive one instance's inputs, clock once, advance both models and check both DUTs.
    task automatic applyStimulus(input int w, input logic rst, input logic flag,
                                 input logic [7:0] req, input logic [7:0] done);
        if (w == 0) begin
            rst4 = rst; flag4 = flag; req4 = req[3:0]; done4 = done[3:0];
        end else begin
            rst8 = rst; flag8 = flag; req8 = req; done8 = done;
        end
        @(posedge clk);
        modelStep(0, 4, 2, 8, rst4, flag4, {4'b0, req4}, {4'b0, done4});
        modelStep(1, 8, 2, 8, rst8, flag8, req8, done8);
        #1;
        checkOutput(0);
        checkOutput(1);
    endtask

    initial begin
        logic [7:0] rq, dn;
        rst4 = 1'b1; flag4 = 1'b1; req4 = 4'hF; done4 = 4'h0;
        rst8 = 1'b1; flag8 = 1'b0; req8 = 8'h00; done8 = 8'h00;

        // Reset with everything requesting, then first grant lands on group 1.
        applyStimulus(0, 1'b1, 1'b1, 8'h0F, 8'h00);
        applyStimulus(0, 1'b1, 1'b1, 8'h0F, 8'h00);
        cmpVal("resetStart", {4'b0, start4}, 8'h00);
        applyStimulus(0, 1'b0, 1'b1, 8'h0F, 8'h00);
        cmpVal("firstGrant", {4'b0, start4}, 8'h02);

        // Budget-driven rotation 1 -> 2 -> 3 -> 0 -> 1 with no idle cycle.
        for (int g = 0; g < 4; g++) begin
            applyStimulus(0, 1'b0, 1'b1, 8'h0F, 8'(1 << mOwner[0]));
            applyStimulus(0, 1'b0, 1'b1, 8'h0F, 8'(1 << mOwner[0]));
        end
        cmpVal("rotWrap", {4'b0, start4}, 8'h02);
        cmpVal("rotEvt", {7'b0, evtB4}, 8'h01);

        // Rotate to 3, then owner drops with 0110 pending: wrap picks group 1.
        for (int g = 0; g < 2; g++) begin
            applyStimulus(0, 1'b0, 1'b1, 8'h0F, 8'(1 << mOwner[0]));
            applyStimulus(0, 1'b0, 1'b1, 8'h0F, 8'(1 << mOwner[0]));
        end
        applyStimulus(0, 1'b0, 1'b1, 8'h06, 8'h00);
        cmpVal("wrapTop", {4'b0, start4}, 8'h02);

        // Move to group 2, then starve it of done until the timeout fires.
        applyStimulus(0, 1'b0, 1'b1, 8'h04, 8'h00);
        for (int c = 0; c < 8; c++) applyStimulus(0, 1'b0, 1'b1, 8'h0F, 8'h00);
        cmpVal("timeoutEvt", {7'b0, evtT4}, 8'h01);
        cmpVal("timeoutNext", {4'b0, start4}, 8'h08);

        // Done on the last allowed cycle restarts the timer and keeps the grant.
        for (int c = 0; c < 7; c++) applyStimulus(0, 1'b0, 1'b1, 8'h0F, 8'h00);
        applyStimulus(0, 1'b0, 1'b1, 8'h0F, 8'h08);
        cmpVal("timerRescue", {4'b0, start4}, 8'h08);
        for (int c = 0; c < 3; c++) applyStimulus(0, 1'b0, 1'b1, 8'h0F, 8'h00);

        // Budget exit while flag is low parks in idle until flag returns.
        applyStimulus(0, 1'b0, 1'b0, 8'h0F, 8'h08);
        cmpVal("flagLowIdle", {4'b0, start4}, 8'h00);
        for (int c = 0; c < 3; c++) applyStimulus(0, 1'b0, 1'b0, 8'h0F, 8'h00);
        applyStimulus(0, 1'b0, 1'b1, 8'h0F, 8'h00);
        cmpVal("flagReturn", {4'b0, start4}, 8'h01);

        // Sole requester 2 with stray done[0] pulses; budget re-grants the same group.
        applyStimulus(0, 1'b0, 1'b1, 8'h04, 8'h00);
        applyStimulus(0, 1'b0, 1'b1, 8'h04, 8'h01);
        applyStimulus(0, 1'b0, 1'b1, 8'h04, 8'h00);
        applyStimulus(0, 1'b0, 1'b1, 8'h04, 8'h01);
        applyStimulus(0, 1'b0, 1'b1, 8'h04, 8'h04);
        applyStimulus(0, 1'b0, 1'b1, 8'h04, 8'h01);
        applyStimulus(0, 1'b0, 1'b1, 8'h04, 8'h04);
        cmpVal("soleRegrant", {4'b0, start4}, 8'h04);
        cmpVal("soleEvt", {7'b0, evtB4}, 8'h01);

        // Random traffic, first with frequent owner done, then sparse to reach timeouts.
        for (int c = 0; c < 500; c++) begin
            rq = 8'($urandom) | 8'($urandom);
            dn = 8'($urandom) & 8'($urandom);
            if ($urandom % ((c < 250) ? 2 : 9) == 0) dn[mOwner[0]] = 1'b1;
            else                                     dn[mOwner[0]] = 1'b0;
            applyStimulus(0, ($urandom % 97) == 0, ($urandom % 6) != 0, rq, dn);
        end

        // Park the 4-group DUT and exercise the 8-group instance.
        applyStimulus(0, 1'b1, 1'b0, 8'h00, 8'h00);
        applyStimulus(1, 1'b1, 1'b1, 8'hFF, 8'h00);
        applyStimulus(1, 1'b0, 1'b1, 8'hFF, 8'h00);
        cmpVal("grant8First", start8, 8'h02);
        for (int g = 0; g < 8; g++) begin
            applyStimulus(1, 1'b0, 1'b1, 8'hFF, 8'(1 << mOwner[1]));
            applyStimulus(1, 1'b0, 1'b1, 8'hFF, 8'(1 << mOwner[1]));
        end
        cmpVal("rot8Wrap", start8, 8'h02);
        for (int c = 0; c < 300; c++) begin
            rq = 8'($urandom) & 8'($urandom);
            dn = 8'($urandom) & 8'($urandom);
            if ($urandom % ((c < 150) ? 2 : 9) == 0) dn[mOwner[1]] = 1'b1;
            else                                     dn[mOwner[1]] = 1'b0;
            applyStimulus(1, ($urandom % 97) == 0, ($urandom % 6) != 0, rq, dn);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
